// File: rtl/phase_accumulator.sv
// Per-operator phase accumulator: applies vibrato to the F-number, scales by block
// and multiplier, and accumulates into a small per-operator phase RAM over a 3-stage pipeline.
module phase_accumulator #(
    parameter int NUM_OPERATORS   = 36,
    parameter int OP_NUM_WIDTH    = 6,
    parameter int PHASE_ACC_WIDTH = 20,
    parameter int VIB_VAL_WIDTH   = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       op_valid,
    input  logic [OP_NUM_WIDTH-1:0]    op_num,
    input  logic [9:0]                 fnum,
    input  logic [2:0]                 block,
    input  logic [3:0]                 mult,
    input  logic                       vib,
    input  logic [VIB_VAL_WIDTH-1:0]   vib_val,
    input  logic                       key_on_pulse,
    output logic                       busy,
    output logic                       out_valid,
    output logic [OP_NUM_WIDTH-1:0]    out_op_num,
    output logic [PHASE_ACC_WIDTH-1:0] phase_out
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam int FNUM_W = 10;
    localparam int PROD_W = 32;
    localparam logic [OP_NUM_WIDTH-1:0] LAST_OP = OP_NUM_WIDTH'(NUM_OPERATORS - 1);
    localparam logic [OP_NUM_WIDTH-1:0] OP_LIMIT = OP_NUM_WIDTH'(NUM_OPERATORS);

    logic [0:0]                 state;
    logic [OP_NUM_WIDTH-1:0]    clear_idx;
    logic [PHASE_ACC_WIDTH-1:0] phase_ram [NUM_OPERATORS];

    logic                       accept;
    logic [FNUM_W-1:0]          vib_ext;
    logic [FNUM_W-1:0]          fnum_v_next;

    logic                       s1_valid;
    logic [OP_NUM_WIDTH-1:0]    s1_op;
    logic [FNUM_W-1:0]          s1_fnum_v;
    logic [2:0]                 s1_block;
    logic [3:0]                 s1_mult;
    logic                       s1_key_on;

    logic [PROD_W-1:0]          shifted;
    logic [PROD_W-1:0]          product;
    logic [PHASE_ACC_WIDTH-1:0] inc_next;
    logic [PHASE_ACC_WIDTH-1:0] old_next;

    logic                       s2_valid;
    logic [OP_NUM_WIDTH-1:0]    s2_op;
    logic [PHASE_ACC_WIDTH-1:0] s2_inc;
    logic [PHASE_ACC_WIDTH-1:0] s2_old;
    logic                       s2_key_on;

    logic [PHASE_ACC_WIDTH-1:0] new_phase;

    // Register codes 11 and 13 repeat the value of their lower neighbour, 15 repeats 14.
    function automatic logic [4:0] mult_x2(input logic [3:0] code);
        logic [4:0] r;
        case (code)
            4'd0:    r = 5'd1;
            4'd1:    r = 5'd2;
            4'd2:    r = 5'd4;
            4'd3:    r = 5'd6;
            4'd4:    r = 5'd8;
            4'd5:    r = 5'd10;
            4'd6:    r = 5'd12;
            4'd7:    r = 5'd14;
            4'd8:    r = 5'd16;
            4'd9:    r = 5'd18;
            4'd10:   r = 5'd20;
            4'd11:   r = 5'd20;
            4'd12:   r = 5'd24;
            4'd13:   r = 5'd24;
            4'd14:   r = 5'd30;
            default: r = 5'd30;
        endcase
        return r;
    endfunction

    assign busy   = (state == ST_CLEAR);
    assign accept = op_valid && !busy && (op_num < OP_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_CLEAR;
            clear_idx <= '0;
        end else if (state == ST_CLEAR) begin
            if (clear_idx == LAST_OP) begin
                state     <= ST_RUN;
                clear_idx <= '0;
            end else begin
                clear_idx <= clear_idx + 1'b1;
            end
        end
    end

    assign vib_ext     = {{(FNUM_W - VIB_VAL_WIDTH){vib_val[VIB_VAL_WIDTH-1]}}, vib_val};
    assign fnum_v_next = vib ? (fnum + vib_ext) : fnum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_op     <= '0;
            s1_fnum_v <= '0;
            s1_block  <= '0;
            s1_mult   <= '0;
            s1_key_on <= 1'b0;
        end else begin
            s1_valid  <= accept;
            s1_op     <= op_num;
            s1_fnum_v <= fnum_v_next;
            s1_block  <= block;
            s1_mult   <= mult;
            s1_key_on <= key_on_pulse;
        end
    end

    assign shifted  = PROD_W'(s1_fnum_v) << s1_block;
    assign product  = shifted * PROD_W'(mult_x2(s1_mult));
    assign inc_next = PHASE_ACC_WIDTH'(product >> 2);

    // The op in stage 3 writes the RAM on this same edge, so its result is forwarded.
    assign old_next = (s2_valid && (s2_op == s1_op)) ? new_phase : phase_ram[s1_op];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_op     <= '0;
            s2_inc    <= '0;
            s2_old    <= '0;
            s2_key_on <= 1'b0;
        end else begin
            s2_valid  <= s1_valid;
            s2_op     <= s1_op;
            s2_inc    <= inc_next;
            s2_old    <= old_next;
            s2_key_on <= s1_key_on;
        end
    end

    assign new_phase = s2_key_on ? '0 : (s2_old + s2_inc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_op_num <= '0;
            phase_out  <= '0;
        end else begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_op_num <= s2_op;
                phase_out  <= new_phase;
            end
        end
    end

    // Single write port shared by the clear sweep and the stage-3 write-back.
    always_ff @(posedge clk) begin
        if (busy) begin
            phase_ram[clear_idx] <= '0;
        end else if (s2_valid) begin
            phase_ram[s2_op] <= new_phase;
        end
    end

endmodule

// File: tb/tb_phase_accumulator.sv
// Self-checking bench for phase_accumulator: directed scenarios plus random traffic
// compared against an arithmetic model of per-operator phases.
module tb_phase_accumulator;

    localparam int NOPS  = 36;
    localparam int PW    = 20;
    localparam longint PMOD = longint'(1) << PW;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic [5:0]  op_num;
    logic [9:0]  fnum;
    logic [2:0]  block;
    logic [3:0]  mult;
    logic        vib;
    logic [2:0]  vib_val;
    logic        key_on_pulse;
    logic        busy;
    logic        out_valid;
    logic [5:0]  out_op_num;
    logic [19:0] phase_out;

    typedef struct {
        int     due;
        int     op;
        longint phase;
    } exp_t;

    exp_t   exp_q [$];
    longint model_phase [NOPS];
    longint last_phase;
    int     mult_tbl [16] = '{1, 2, 4, 6, 8, 10, 12, 14, 16, 18, 20, 20, 24, 24, 30, 30};
    int     cycle;
    int     n_checks;
    int     n_fail;

    phase_accumulator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op_valid     (op_valid),
        .op_num       (op_num),
        .fnum         (fnum),
        .block        (block),
        .mult         (mult),
        .vib          (vib),
        .vib_val      (vib_val),
        .key_on_pulse (key_on_pulse),
        .busy         (busy),
        .out_valid    (out_valid),
        .out_op_num   (out_op_num),
        .phase_out    (phase_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < NOPS; i++) model_phase[i] = 0;
        last_phase = 0;
    endtask

    // Drive one slot just after a rising edge and record what the design must emit 3 cycles later.
    task automatic drive(input bit valid, input int op, input int fn, input int blk, input int ml,
                         input bit v, input int vv, input bit ko);
        int     sv;
        int     fv;
        longint inc;
        longint np;
        exp_t   e;
        @(posedge clk);
        #1;
        op_valid     = valid;
        op_num       = 6'(op);
        fnum         = 10'(fn);
        block        = 3'(blk);
        mult         = 4'(ml);
        vib          = v;
        vib_val      = 3'(vv);
        key_on_pulse = ko;
        if (valid && op < NOPS) begin
            sv = (vv >= 4) ? vv - 8 : vv;
            fv = v ? (((fn + sv) % 1024) + 1024) % 1024 : fn;
            inc = ((longint'(fv) * (longint'(1) << blk)) * mult_tbl[ml] / 4) % PMOD;
            np = ko ? 0 : (model_phase[op] + inc) % PMOD;
            model_phase[op] = np;
            e.due   = cycle + 3;
            e.op    = op;
            e.phase = np;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 0, 1'b0, 0, 1'b0);
    endtask

    // Busy must stay high for exactly NOPS sampled cycles after release; requests are offered meanwhile.
    task automatic clear_check();
        for (int k = 0; k < NOPS; k++) begin
            @(negedge clk);
            check("busy_during_clear", 32'(busy), 32'd1);
            op_valid = 1'b1;
            op_num   = 6'(k);
            fnum     = 10'd100;
            block    = 3'd7;
            mult     = 4'd15;
        end
        @(negedge clk);
        op_valid = 1'b0;
        check("busy_after_clear", 32'(busy), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cycle    = 0;
        rst_n    = 1'b0;
        op_valid = 1'b0;
        op_num   = '0;
        fnum     = '0;
        block    = '0;
        mult     = '0;
        vib      = 1'b0;
        vib_val  = '0;
        key_on_pulse = 1'b0;
        model_reset();

        fork
            forever begin
                @(posedge clk);
                cycle++;
            end
            forever begin
                exp_t e;
                @(negedge clk);
                if (exp_q.size() > 0 && exp_q[0].due == cycle) begin
                    e = exp_q.pop_front();
                    check("out_valid", 32'(out_valid), 32'd1);
                    check("out_op_num", 32'(out_op_num), 32'(e.op));
                    check("phase_out", 32'(phase_out), 32'(e.phase));
                    last_phase = e.phase;
                end else begin
                    check("out_valid_idle", 32'(out_valid), 32'd0);
                    check("phase_hold", 32'(phase_out), 32'(last_phase));
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd1);
        check("reset_out_op_num", 32'(out_op_num), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_check();

        $display("[TB] first requests after clear");
        for (int i = 0; i < 4; i++) drive(1'b1, i, 0, 3, 5, 1'b0, 0, 1'b0);
        idle(3);

        $display("[TB] op 5 accumulating over sample periods");
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5, 512, 4, 1, 1'b0, 0, 1'b0);
            idle(4);
        end

        $display("[TB] vibrato offsets");
        drive(1'b1, 10, 512, 0, 1, 1'b1, 3, 1'b0);
        drive(1'b1, 11, 512, 0, 1, 1'b1, 5, 1'b0);
        drive(1'b1, 12, 512, 0, 1, 1'b0, 3, 1'b0);
        drive(1'b1, 13, 0, 0, 1, 1'b1, 7, 1'b0);
        idle(3);

        $display("[TB] back-to-back forwarding on op 2");
        for (int i = 0; i < 4; i++) drive(1'b1, 2, 1023, 7, 15, 1'b0, 0, 1'b0);
        idle(3);

        $display("[TB] key-on on op 7");
        drive(1'b1, 7, 300, 3, 2, 1'b0, 0, 1'b0);
        drive(1'b1, 7, 300, 3, 2, 1'b0, 0, 1'b0);
        drive(1'b1, 7, 300, 3, 2, 1'b0, 0, 1'b1);
        drive(1'b1, 7, 300, 3, 2, 1'b0, 0, 1'b0);
        drive(1'b0, 7, 300, 3, 2, 1'b0, 0, 1'b1);
        drive(1'b1, 7, 300, 3, 2, 1'b0, 0, 1'b0);
        idle(3);

        $display("[TB] out-of-range operators dropped");
        drive(1'b1, 36, 512, 4, 1, 1'b0, 0, 1'b0);
        drive(1'b1, 63, 512, 4, 1, 1'b0, 0, 1'b0);
        drive(1'b1, 5, 512, 4, 1, 1'b0, 0, 1'b0);
        idle(3);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 3) != 0), $urandom_range(0, 39), $urandom_range(0, 1023),
                  $urandom_range(0, 7), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7), ($urandom_range(0, 15) == 0));
        end
        idle(3);

        $display("[TB] reset with requests in flight");
        drive(1'b1, 20, 700, 5, 3, 1'b0, 0, 1'b0);
        drive(1'b1, 21, 700, 5, 3, 1'b0, 0, 1'b0);
        drive(1'b1, 22, 700, 5, 3, 1'b0, 0, 1'b0);
        #1;
        rst_n    = 1'b0;
        op_valid = 1'b0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check("busy_in_reset", 32'(busy), 32'd1);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_check();
        for (int i = 0; i < NOPS; i++) drive(1'b1, i, 0, 0, 0, 1'b0, 0, 1'b0);
        idle(5);

        check("drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
